// File: rtl/crc_pkg.sv
// Shared constants and types for the serial CRC-32 frame checker.
package crc_pkg;

  localparam int unsigned CRC_W = 32;
  localparam logic [CRC_W-1:0] CRC32_POLY_REV = 32'hEDB88320;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The port carries the generator LSB first; the shifter wants it MSB first.
  function automatic logic [CRC_W-1:0] bit_reverse(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < CRC_W; k++) begin
      r[k] = v[CRC_W-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_serial_step.sv
// One bit of MSB-first polynomial division: shift the remainder, fold in the generator.
module crc32_serial_step
  import crc_pkg::*;
(
  input  logic [CRC_W-1:0] rem_i,
  input  logic             bit_i,
  input  logic [CRC_W-1:0] poly_i,
  output logic [CRC_W-1:0] rem_o
);

  logic fb;

  always_comb begin
    fb    = rem_i[CRC_W-1] ^ bit_i;
    rem_o = {rem_i[CRC_W-2:0], 1'b0} ^ (fb ? poly_i : '0);
  end

endmodule

// File: rtl/crc32_checker.sv
// Serial CRC-32 frame checker: one bit per cycle, 33 cycles per word, a
// one-cycle verdict after the last word of a frame.
module crc32_checker
  import crc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CRC_W-1:0] polynomial_i,
  input  logic [CRC_W-1:0] data_i,
  input  logic             valid_i,
  input  logic             last_i,
  input  logic             clear_i,
  output logic             ready_o,
  output logic             result_valid_o,
  output logic             crc_ok_o,
  output logic [CRC_W-1:0] residue_o,
  output logic [15:0]      frame_words_o
);

  state_e           state_q, state_d;
  logic [CRC_W-1:0] rem_q, rem_d;
  logic [CRC_W-1:0] rem_step;
  logic [4:0]       cnt_q, cnt_d;
  logic [15:0]      words_q, words_d;
  logic [CRC_W-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [CRC_W-1:0] poly_q, poly_d;
  logic [CRC_W-1:0] residue_q, residue_d;
  logic             ok_q, ok_d;
  logic [15:0]      fw_q, fw_d;

  crc32_serial_step u_step (
    .rem_i  (rem_q),
    .bit_i  (data_q[cnt_q]),
    .poly_i (poly_q),
    .rem_o  (rem_step)
  );

  assign ready_o        = (state_q == IDLE);
  assign result_valid_o = (state_q == DONE);
  assign crc_ok_o       = ok_q;
  assign residue_o      = residue_q;
  assign frame_words_o  = fw_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
    data_d    = data_q;
    last_d    = last_q;
    poly_d    = poly_q;
    residue_d = residue_q;
    ok_d      = ok_q;
    fw_d      = fw_q;

    if (clear_i) begin
      state_d = IDLE;
      rem_d   = '0;
      words_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            data_d  = data_i;
            last_d  = last_i;
            cnt_d   = 5'd31;
            state_d = SHIFT;
            words_d = (words_q == '1) ? words_q : words_q + 16'd1;
            // A zero word count marks the first word of a new frame.
            if (words_q == '0) begin
              poly_d = bit_reverse(polynomial_i);
            end
          end
        end
        SHIFT: begin
          rem_d = rem_step;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == '0) begin
            if (last_q) begin
              state_d   = DONE;
              residue_d = rem_step;
              ok_d      = (rem_step == '0);
              fw_d      = words_q;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          rem_d   = '0;
          words_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      cnt_q     <= '0;
      words_q   <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      poly_q    <= '0;
      residue_q <= '0;
      ok_q      <= 1'b0;
      fw_q      <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      words_q   <= words_d;
      data_q    <= data_d;
      last_q    <= last_d;
      poly_q    <= poly_d;
      residue_q <= residue_d;
      ok_q      <= ok_d;
      fw_q      <= fw_d;
    end
  end

endmodule
